// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART command receive path.
package uart_pkg;

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} rx_state_t;

  // Clocks per oversample tick, truncated.
  function automatic int unsigned calc_div(input int unsigned clk_hz,
                                           input int unsigned baud,
                                           input int unsigned os);
    return clk_hz / (baud * os);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO; a push into a full FIFO succeeds only alongside a pop.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [LW-1:0]    level_q;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (level_q == LW'(DEPTH));
  assign empty_o = (level_q == '0);
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];
  assign level_o = level_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   level_q <= level_q + LW'(1);
        2'b01:   level_q <= level_q - LW'(1);
        default: level_q <= level_q;
      endcase
    end
  end

  // Storage carries no reset; empty gating hides stale contents.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/uart_cmd_rx.sv
// 8N1 UART receiver feeding the instruction decoder through a byte FIFO,
// with frame-error and overrun pulses.
module uart_cmd_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 100_000_000,
  parameter int unsigned BAUD       = 9600,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          rx,
  output logic [7:0]                    rx_data,
  output logic                          rx_valid,
  input  logic                          rx_ready,
  output logic                          frame_err,
  output logic                          overrun,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int unsigned DIV   = calc_div(CLK_HZ, BAUD, OVERSAMPLE);
  localparam int unsigned DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned SMP_W = $clog2(OVERSAMPLE);
  localparam int unsigned MID   = OVERSAMPLE / 2 - 1;

  logic             rx_meta_q;
  logic             rx_s_q;
  logic             rx_prev_q;
  logic [DIV_W-1:0] div_cnt_q;
  logic             tick;
  logic             start_edge;
  rx_state_t        state_q;
  logic [SMP_W-1:0] smp_cnt_q;
  logic [2:0]       bit_cnt_q;
  logic [7:0]       shift_q;
  logic             push_q;
  logic             frame_err_q;
  logic             overrun_q;
  logic             fifo_full;
  logic             fifo_empty;
  logic             pop;

  assign tick       = (div_cnt_q == DIV_W'(DIV - 1));
  assign start_edge = (state_q == IDLE) && rx_prev_q && !rx_s_q;
  assign rx_valid   = !fifo_empty;
  assign pop        = rx_valid && rx_ready;
  assign frame_err  = frame_err_q;
  assign overrun    = overrun_q;

  // Synchroniser, edge-detect history and free-running tick divider.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      rx_prev_q <= 1'b1;
      div_cnt_q <= '0;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
      rx_prev_q <= rx_s_q;
      if (start_edge || tick) div_cnt_q <= '0;
      else                    div_cnt_q <= div_cnt_q + DIV_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      smp_cnt_q   <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      push_q      <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      push_q      <= 1'b0;
      frame_err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_edge) begin
            state_q   <= START;
            smp_cnt_q <= '0;
          end
        end
        START: begin
          if (tick) begin
            if (smp_cnt_q == SMP_W'(MID)) begin
              smp_cnt_q <= '0;
              bit_cnt_q <= '0;
              state_q   <= rx_s_q ? IDLE : DATA;
            end else begin
              smp_cnt_q <= smp_cnt_q + SMP_W'(1);
            end
          end
        end
        DATA: begin
          if (tick) begin
            if (smp_cnt_q == SMP_W'(OVERSAMPLE - 1)) begin
              smp_cnt_q <= '0;
              shift_q   <= {rx_s_q, shift_q[7:1]};
              bit_cnt_q <= bit_cnt_q + 3'd1;
              if (bit_cnt_q == 3'd7) state_q <= STOP;
            end else begin
              smp_cnt_q <= smp_cnt_q + SMP_W'(1);
            end
          end
        end
        STOP: begin
          if (tick) begin
            if (smp_cnt_q == SMP_W'(OVERSAMPLE - 1)) begin
              smp_cnt_q <= '0;
              if (rx_s_q) begin
                push_q  <= 1'b1;
                state_q <= IDLE;
              end else begin
                frame_err_q <= 1'b1;
                state_q     <= BREAK;
              end
            end else begin
              smp_cnt_q <= smp_cnt_q + SMP_W'(1);
            end
          end
        end
        BREAK: begin
          // A held-low line must return high before a new start edge counts.
          if (rx_s_q) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Overrun: the byte is lost only when full and nothing leaves that cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) overrun_q <= 1'b0;
    else        overrun_q <= push_q && fifo_full && !pop;
  end

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push_q),
    .wdata_i (shift_q),
    .pop_i   (pop),
    .rdata_o (rx_data),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_level)
  );

endmodule

// File: tb/tb_uart_cmd_rx.sv
// Directed bench for uart_cmd_rx at DIV=10 (160 clk per bit).
module tb_uart_cmd_rx;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready = 1'b0;
  logic       frame_err;
  logic       overrun;
  logic [3:0] fifo_level;

  int checks = 0;
  int passed = 0;

  // Running event counts and popped-byte log, sampled on the falling edge.
  int         valid_cycles = 0;
  int         fe_cnt = 0;
  int         ov_cnt = 0;
  int         both_cnt = 0;
  logic [7:0] popped[$];

  uart_cmd_rx #(
    .CLK_HZ     (1_600_000),
    .BAUD       (10_000),
    .OVERSAMPLE (16),
    .FIFO_DEPTH (8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx         (rx),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .fifo_level (fifo_level)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rx_valid) valid_cycles++;
    if (rx_valid && rx_ready) popped.push_back(rx_data);
    if (frame_err) fe_cnt++;
    if (overrun) ov_cnt++;
    if (frame_err && overrun) both_cnt++;
  end

  // Line is left at the stop-bit value when the task returns.
  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    @(posedge clk);
    #1 rx = 1'b0;
    repeat (160) @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      #1 rx = b[i];
      repeat (160) @(posedge clk);
    end
    #1 rx = stop_bit;
    repeat (160) @(posedge clk);
  endtask

  task automatic settle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    settle(3);
    checks++; if (rx_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", rx_valid); else passed++;
    checks++; if (rx_data !== 8'h00) $display("FAIL reset_data: got %h want 00", rx_data); else passed++;
    checks++; if (fifo_level !== 4'd0) $display("FAIL reset_level: got %0d want 0", fifo_level); else passed++;
    checks++; if ({frame_err, overrun} !== 2'b00) $display("FAIL reset_flags: got %b want 00", {frame_err, overrun}); else passed++;
    rst_n = 1'b1;
    settle(5);
  endtask

  task automatic test_single_byte();
    int pb, vb, fb, ob;
    rx_ready = 1'b1;
    pb = popped.size(); vb = valid_cycles; fb = fe_cnt; ob = ov_cnt;
    send_byte(8'hA5, 1'b1);
    settle(20);
    checks++; if (popped.size() - pb !== 1) $display("FAIL single_count: got %0d want 1", popped.size() - pb); else passed++;
    checks++; if (popped[pb] !== 8'hA5) $display("FAIL single_data: got %h want a5", popped[pb]); else passed++;
    checks++; if (valid_cycles - vb !== 1) $display("FAIL single_valid_width: got %0d want 1", valid_cycles - vb); else passed++;
    checks++; if (fe_cnt - fb + ov_cnt - ob !== 0) $display("FAIL single_flags: got %0d want 0", fe_cnt - fb + ov_cnt - ob); else passed++;
    rx_ready = 1'b0;
  endtask

  task automatic test_overrun();
    int pb, ob;
    logic [7:0] exp_b;
    rx_ready = 1'b0;
    for (int i = 0; i < 8; i++) send_byte(8'h31 + 8'(i), 1'b1);
    settle(20);
    checks++; if (fifo_level !== 4'd8) $display("FAIL ovr_fill_level: got %0d want 8", fifo_level); else passed++;
    ob = ov_cnt;
    send_byte(8'h39, 1'b1);
    settle(20);
    checks++; if (ov_cnt - ob !== 1) $display("FAIL ovr_pulse: got %0d want 1", ov_cnt - ob); else passed++;
    checks++; if (fifo_level !== 4'd8) $display("FAIL ovr_level_after: got %0d want 8", fifo_level); else passed++;
    pb = popped.size();
    rx_ready = 1'b1;
    settle(12);
    rx_ready = 1'b0;
    checks++; if (popped.size() - pb !== 8) $display("FAIL ovr_drain_count: got %0d want 8", popped.size() - pb); else passed++;
    for (int i = 0; i < 8; i++) begin
      exp_b = 8'h31 + 8'(i);
      checks++; if (popped[pb + i] !== exp_b) $display("FAIL ovr_drain_%0d: got %h want %h", i, popped[pb + i], exp_b); else passed++;
    end
    checks++; if (fifo_level !== 4'd0) $display("FAIL ovr_empty_level: got %0d want 0", fifo_level); else passed++;
  endtask

  task automatic test_glitch();
    int vb, fb, ob;
    vb = valid_cycles; fb = fe_cnt; ob = ov_cnt;
    @(posedge clk);
    #1 rx = 1'b0;
    repeat (40) @(posedge clk);
    #1 rx = 1'b1;
    settle(300);
    checks++; if (fifo_level !== 4'd0) $display("FAIL glitch_level: got %0d want 0", fifo_level); else passed++;
    checks++; if (valid_cycles - vb !== 0) $display("FAIL glitch_valid: got %0d want 0", valid_cycles - vb); else passed++;
    checks++; if (fe_cnt - fb !== 0) $display("FAIL glitch_frame_err: got %0d want 0", fe_cnt - fb); else passed++;
    checks++; if (ov_cnt - ob !== 0) $display("FAIL glitch_overrun: got %0d want 0", ov_cnt - ob); else passed++;
  endtask

  task automatic test_frame_error();
    int pb, fb, ob, bb;
    rx_ready = 1'b1;
    pb = popped.size(); fb = fe_cnt; ob = ov_cnt; bb = both_cnt;
    send_byte(8'h55, 1'b0);
    repeat (500) @(posedge clk);
    #1 rx = 1'b1;
    repeat (200) @(posedge clk);
    send_byte(8'h12, 1'b1);
    settle(20);
    checks++; if (fe_cnt - fb !== 1) $display("FAIL ferr_pulse: got %0d want 1", fe_cnt - fb); else passed++;
    checks++; if (both_cnt - bb !== 0) $display("FAIL ferr_with_overrun: got %0d want 0", both_cnt - bb); else passed++;
    checks++; if (ov_cnt - ob !== 0) $display("FAIL ferr_overrun: got %0d want 0", ov_cnt - ob); else passed++;
    checks++; if (popped.size() - pb !== 1) $display("FAIL ferr_count: got %0d want 1", popped.size() - pb); else passed++;
    checks++; if (popped[pb] !== 8'h12) $display("FAIL ferr_data: got %h want 12", popped[pb]); else passed++;
    rx_ready = 1'b0;
  endtask

  // Push of the 9th byte lands on edge 1524 after the send starts.
  task automatic test_full_push_pop();
    int pb, ob;
    logic [7:0] exp_b;
    rx_ready = 1'b0;
    for (int i = 0; i < 8; i++) send_byte(8'h40 + 8'(i), 1'b1);
    settle(20);
    checks++; if (fifo_level !== 4'd8) $display("FAIL pp_fill_level: got %0d want 8", fifo_level); else passed++;
    ob = ov_cnt; pb = popped.size();
    fork
      send_byte(8'h48, 1'b1);
      begin
        @(posedge clk);
        repeat (1523) @(posedge clk);
        #1 rx_ready = 1'b1;
        @(posedge clk);
        #1 rx_ready = 1'b0;
      end
    join
    settle(20);
    checks++; if (fifo_level !== 4'd8) $display("FAIL pp_level: got %0d want 8", fifo_level); else passed++;
    checks++; if (ov_cnt - ob !== 0) $display("FAIL pp_overrun: got %0d want 0", ov_cnt - ob); else passed++;
    checks++; if (popped.size() - pb !== 1) $display("FAIL pp_pop_count: got %0d want 1", popped.size() - pb); else passed++;
    rx_ready = 1'b1;
    settle(12);
    rx_ready = 1'b0;
    checks++; if (popped.size() - pb !== 9) $display("FAIL pp_drain_count: got %0d want 9", popped.size() - pb); else passed++;
    for (int i = 0; i < 9; i++) begin
      exp_b = 8'h40 + 8'(i);
      checks++; if (popped[pb + i] !== exp_b) $display("FAIL pp_order_%0d: got %h want %h", i, popped[pb + i], exp_b); else passed++;
    end
  endtask

  task automatic test_reset_mid_frame();
    int pb, fb, ob;
    rx_ready = 1'b0;
    for (int i = 1; i <= 3; i++) send_byte(8'(i), 1'b1);
    settle(20);
    checks++; if (fifo_level !== 4'd3) $display("FAIL rst_pre_level: got %0d want 3", fifo_level); else passed++;
    pb = popped.size();
    fork
      send_byte(8'hC3, 1'b1);
      begin
        @(posedge clk);
        repeat (880) @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        checks++; if (rx_valid !== 1'b0) $display("FAIL rst_mid_valid: got %b want 0", rx_valid); else passed++;
        checks++; if (rx_data !== 8'h00) $display("FAIL rst_mid_data: got %h want 00", rx_data); else passed++;
        checks++; if (fifo_level !== 4'd0) $display("FAIL rst_mid_level: got %0d want 0", fifo_level); else passed++;
        checks++; if ({frame_err, overrun} !== 2'b00) $display("FAIL rst_mid_flags: got %b want 00", {frame_err, overrun}); else passed++;
      end
    join
    // The still-low line after reset reads as a start edge; bits 5..stop decode to 0xFF.
    settle(1000);
    rx_ready = 1'b1;
    settle(10);
    rx_ready = 1'b0;
    checks++; if (popped.size() - pb !== 1) $display("FAIL rst_residue_count: got %0d want 1", popped.size() - pb); else passed++;
    checks++; if (popped[pb] !== 8'hFF) $display("FAIL rst_residue_data: got %h want ff", popped[pb]); else passed++;
    pb = popped.size(); fb = fe_cnt; ob = ov_cnt;
    rx_ready = 1'b1;
    send_byte(8'h7E, 1'b1);
    settle(20);
    checks++; if (popped.size() - pb !== 1) $display("FAIL rst_next_count: got %0d want 1", popped.size() - pb); else passed++;
    checks++; if (popped[pb] !== 8'h7E) $display("FAIL rst_next_data: got %h want 7e", popped[pb]); else passed++;
    checks++; if (fe_cnt - fb + ov_cnt - ob !== 0) $display("FAIL rst_next_flags: got %0d want 0", fe_cnt - fb + ov_cnt - ob); else passed++;
    checks++; if (fifo_level !== 4'd0) $display("FAIL rst_next_level: got %0d want 0", fifo_level); else passed++;
    rx_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_overrun();
    test_glitch();
    test_frame_error();
    test_full_push_pop();
    test_reset_mid_frame();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
